// File: rtl/time_set_pkg.sv
// time_set_pkg: shared types and helpers for the time-set controller.
//   mode_t      : field being edited, value is driven straight onto field_sel.
//   rep_state_t : up/down auto-repeat state machine.
//   BTN_*       : bit positions of the buttons in the debouncer instance array.
package time_set_pkg;

  typedef enum logic [1:0] {
    MODE_RUN = 2'd0,
    MODE_HR  = 2'd1,
    MODE_MIN = 2'd2,
    MODE_SEC = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    REP_IDLE    = 2'd0,
    REP_DELAY   = 2'd1,
    REP_REPEAT  = 2'd2,
    REP_LOCKOUT = 2'd3
  } rep_state_t;

  localparam int BTN_UP   = 0;
  localparam int BTN_DN   = 1;
  localparam int BTN_MODE = 2;
  localparam int NUM_BTN  = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // RUN -> HR -> MIN -> SEC -> RUN: the 2-bit wrap does the last step.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and rising-edge detector
// for one raw push button.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous bouncing button (1 = pressed)
//   level    : debounced level
//   press    : one-cycle pulse, the cycle after level rises
module btn_debounce
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], raw};
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Count consecutive cycles where the synced input disagrees with the
      // current level; any agreement restarts the count.
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_TOP) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button front end for setting a clock. A mode button walks
// through RUN/HR/MIN/SEC; up/down buttons issue single-cycle add/minus steps
// with hold-to-repeat.
//   clk, rst          : clock, synchronous active-high reset
//   btn_up/down/mode  : raw bouncing buttons (1 = pressed)
//   add, minus        : one-cycle step requests to the selected field changer
//   field_sel         : 0 run, 1 hours, 2 minutes, 3 seconds
//   editing           : field_sel != 0
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  output logic       add,
  output logic       minus,
  output logic [1:0] field_sel,
  output logic       editing
);

  localparam int REP_MAX = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int CNT_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_TOP  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TOP = CNT_W'(REPEAT_RATE - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;

  assign w_raw = {btn_mode, btn_down, btn_up};

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (w_raw),
    .level (w_level),
    .press (w_press)
  );

  mode_t            r_mode, w_mode_nxt;
  rep_state_t       r_rep, w_rep_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;   // 1 = up, 0 = down
  logic             w_step;
  logic             w_mode_pulse;
  logic             w_up, w_dn, w_both, w_act;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_up         = w_level[BTN_UP];
  assign w_dn         = w_level[BTN_DN];
  assign w_both       = w_up & w_dn;
  assign w_act        = r_dir ? w_up : w_dn;
  assign w_mode_pulse = w_press[BTN_MODE] & w_level[BTN_MODE];
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_RUN;
      r_rep  <= REP_IDLE;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_rep  <= w_rep_nxt;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_rep_nxt  = r_rep;
    w_cnt_nxt  = r_cnt;
    w_dir_nxt  = r_dir;
    w_step     = 1'b0;

    if (w_mode_pulse) w_mode_nxt = next_mode(r_mode);

    // A field change or both buttons down parks the repeat logic until
    // both buttons are released, so a held button never leaks into the
    // next field.
    if (w_mode_pulse || w_both) begin
      w_rep_nxt = REP_LOCKOUT;
      w_cnt_nxt = '0;
    end else begin
      unique case (r_rep)
        REP_IDLE: begin
          if (w_press[BTN_UP] && w_up && !w_dn) begin
            w_step = 1'b1; w_dir_nxt = 1'b1;
            w_rep_nxt = REP_DELAY; w_cnt_nxt = '0;
          end else if (w_press[BTN_DN] && w_dn && !w_up) begin
            w_step = 1'b1; w_dir_nxt = 1'b0;
            w_rep_nxt = REP_DELAY; w_cnt_nxt = '0;
          end
        end
        REP_DELAY: begin
          if (!w_act) begin
            w_rep_nxt = REP_IDLE; w_cnt_nxt = '0;
          end else if (r_cnt == DLY_TOP) begin
            w_step = 1'b1; w_rep_nxt = REP_REPEAT; w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        REP_REPEAT: begin
          if (!w_act) begin
            w_rep_nxt = REP_IDLE; w_cnt_nxt = '0;
          end else if (r_cnt == RATE_TOP) begin
            w_step = 1'b1; w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        REP_LOCKOUT: begin
          if (!w_up && !w_dn) w_rep_nxt = REP_IDLE;
        end
        default: w_rep_nxt = REP_IDLE;
      endcase
    end
  end

  // Steps are only forwarded while editing; rst masks everything at once
  // so a pending step in the reset cycle is dropped.
  logic w_step_en;
  assign w_step_en = w_step & (r_mode != MODE_RUN) & ~rst;
  assign add       = w_step_en & w_dir_nxt;
  assign minus     = w_step_en & ~w_dir_nxt;
  assign field_sel = rst ? 2'd0 : r_mode;
  assign editing   = (field_sel != 2'd0);

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int LAT = 2 + DEB + 1;   // raw edge -> press pulse

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_down, btn_mode;
  logic       add, minus, editing;
  logic [1:0] field_sel;

  time_set_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_mode(btn_mode), .add(add), .minus(minus),
    .field_sel(field_sel), .editing(editing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse recorder: each entry is the cycle number the pulse was seen in
  int add_q[$];
  int min_q[$];
  int both_hi = 0;
  always @(negedge clk) begin
    if (add) add_q.push_back(cyc);
    if (minus) min_q.push_back(cyc);
    if (add && minus) both_hi++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    add_q.delete();
    min_q.delete();
  endtask

  task automatic mode_clean();
    btn_mode = 1'b1; tick(10);
    btn_mode = 1'b0; tick(10);
  endtask

  // 1-cycle bounce on both press and release
  task automatic mode_bouncy();
    btn_mode = 1'b1; tick(1);
    btn_mode = 1'b0; tick(1);
    btn_mode = 1'b1; tick(1);
    btn_mode = 1'b0; tick(1);
    btn_mode = 1'b1; tick(12);
    btn_mode = 1'b0; tick(1);
    btn_mode = 1'b1; tick(1);
    btn_mode = 1'b0; tick(12);
  endtask

  typedef struct {
    logic up, dn, md;
    int   cycles;
    int   fs, ed, n_add, n_min;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int s, p;
    int exp_q[$];

    tbl[0]  = '{1'b0, 1'b0, 1'b0,  10, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 100, 0, 0, 0, 0};  // up in RUN: no add
    tbl[2]  = '{1'b0, 1'b0, 1'b0,  10, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0,  30, 0, 0, 0, 0};  // down in RUN: no minus
    tbl[4]  = '{1'b0, 1'b0, 1'b0,  10, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1,  10, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0,  10, 1, 1, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0,  15, 1, 1, 1, 0};  // short tap: one add
    tbl[8]  = '{1'b0, 1'b0, 1'b0,  10, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0,  15, 1, 1, 0, 1};  // short tap: one minus
    tbl[10] = '{1'b0, 1'b0, 1'b0,  10, 1, 1, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1,  10, 2, 1, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0,  10, 2, 1, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1,  10, 3, 1, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 1'b0,  10, 3, 1, 0, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b1,  10, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 1'b0,  10, 0, 0, 0, 0};

    // reset with mode held: press only after full debounce once rst drops
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b1;
    tick(3);
    chk("rst_add", int'(add), 0);
    chk("rst_minus", int'(minus), 0);
    chk("rst_fs", int'(field_sel), 0);
    chk("rst_editing", int'(editing), 0);
    rst = 1'b0;
    tick(LAT);
    chk("held_mode_before_latency", int'(field_sel), 0);
    tick(1);
    chk("held_mode_after_latency", int'(field_sel), 1);
    btn_mode = 1'b0; tick(10);
    mode_clean(); mode_clean(); mode_clean();
    chk("back_to_run", int'(field_sel), 0);

    // table-driven
    for (int i = 0; i < 17; i++) begin
      clr();
      btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_mode = tbl[i].md;
      tick(tbl[i].cycles);
      chk($sformatf("row%0d_fs", i), int'(field_sel), tbl[i].fs);
      chk($sformatf("row%0d_editing", i), int'(editing), tbl[i].ed);
      chk($sformatf("row%0d_adds", i), add_q.size(), tbl[i].n_add);
      chk($sformatf("row%0d_minus", i), min_q.size(), tbl[i].n_min);
    end

    // bouncy mode presses advance exactly once each
    clr();
    mode_bouncy(); chk("bouncy1_fs", int'(field_sel), 1);
    mode_bouncy(); chk("bouncy2_fs", int'(field_sel), 2);
    mode_bouncy(); chk("bouncy3_fs", int'(field_sel), 3);
    chk("bouncy_no_steps", add_q.size() + min_q.size(), 0);
    mode_clean(); mode_clean(); mode_clean();
    chk("min_field_fs", int'(field_sel), 2);

    // hold up: pulses at press, +20, then every 5 while held
    clr();
    btn_up = 1'b1; s = cyc; p = s + LAT;
    tick(LAT + 52);                 // level falls at p+58: p+55 seen, p+60 not
    btn_up = 1'b0;
    tick(40);
    exp_q.delete();
    exp_q.push_back(p);
    for (int t = RD; t <= 55; t += RR) exp_q.push_back(p + t);
    chk("repeat_count", add_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < add_q.size(); i++)
      chk($sformatf("repeat_t%0d", exp_q[i] - p), add_q[i], exp_q[i]);
    chk("repeat_no_minus", min_q.size(), 0);

    // both buttons: lockout until both released
    clr();
    btn_up = 1'b1; tick(40);
    chk("pre_lock_adds", add_q.size(), 4);
    btn_down = 1'b1; tick(DEB + 2);
    clr();
    tick(30);
    chk("both_held_adds", add_q.size(), 0);
    chk("both_held_minus", min_q.size(), 0);
    btn_down = 1'b0; tick(30);
    chk("down_rel_adds", add_q.size(), 0);
    chk("down_rel_minus", min_q.size(), 0);
    btn_up = 1'b0; tick(20);
    chk("both_rel_steps", add_q.size() + min_q.size(), 0);
    btn_down = 1'b1; tick(12); btn_down = 1'b0; tick(15);
    chk("post_lock_minus", min_q.size(), 1);
    chk("post_lock_adds", add_q.size(), 0);

    // mode press while down held: new field gets nothing until re-press
    mode_clean(); mode_clean(); mode_clean();
    chk("hr_fs", int'(field_sel), 1);
    clr();
    btn_down = 1'b1; tick(10);
    chk("hr_minus_first", min_q.size(), 1);
    clr();
    btn_mode = 1'b1; tick(12); btn_mode = 1'b0; tick(10);
    chk("mode_while_held_fs", int'(field_sel), 2);
    chk("mode_while_held_minus", min_q.size(), 0);
    tick(40);
    chk("still_held_minus", min_q.size(), 0);
    btn_down = 1'b0; tick(10);
    chk("released_minus", min_q.size(), 0);
    btn_down = 1'b1; tick(12); btn_down = 1'b0; tick(12);
    chk("repress_minus", min_q.size(), 1);

    // reset between repeat pulses cancels the pending step
    clr();
    btn_up = 1'b1; s = cyc;
    tick(LAT + RD + 2);             // pulses at +7, +27; next due at +32
    chk("pre_rst_adds", add_q.size(), 2);
    rst = 1'b1; tick(1);
    chk("mid_rst_add", int'(add), 0);
    chk("mid_rst_minus", int'(minus), 0);
    chk("mid_rst_fs", int'(field_sel), 0);
    chk("mid_rst_editing", int'(editing), 0);
    rst = 1'b0;
    clr();
    tick(30);
    chk("post_rst_adds", add_q.size(), 0);
    chk("post_rst_fs", int'(field_sel), 0);
    btn_up = 1'b0; tick(10);

    chk("add_minus_exclusive", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
